// File: rtl/fifo_arb_pkg.sv
// ----------------------------------------------------------------------------
// fifo_arb_pkg : shared types and helpers for the FIFO write-port arbiter
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      OWN  = 1'b1
   } arb_state_t;

   // A single requester still needs a one-bit index.
   function automatic int owner_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int rr_next(input int idx, input int n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker : combinational rotate-priority encoder, searches upward from rr_ptr
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rr_picker
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int OWN_W   = owner_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [OWN_W-1:0]   rr_ptr,
   output logic [OWN_W-1:0]   pick,
   output logic               any_req
);

   // Walk from the farthest candidate back to rr_ptr so the nearest hit wins.
   always_comb begin
      int w_idx;
      w_idx = 0;
      pick  = rr_ptr;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_idx = int'(rr_ptr) + k;
         if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
         if (req[w_idx]) pick = OWN_W'(w_idx);
      end
   end

   assign any_req = |req;

endmodule

`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// fifo_wr_arbiter : round-robin burst arbiter sharing one FIFO write port
// Revision        : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 16,
   parameter int MAX_BURST  = 4,
   parameter int OWN_W      = owner_width(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   input  logic [NUM_REQ-1:0]            req_last,
   output logic [NUM_REQ-1:0]            gnt,
   input  logic                          fifo_wr_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [OWN_W-1:0]              owner,
   output logic                          busy
);

   localparam int                CNT_W       = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W:0]    c_max_burst = (CNT_W + 1)'(MAX_BURST);

   arb_state_t              r_state;
   logic [OWN_W-1:0]        r_owner;
   logic [OWN_W-1:0]        r_rr_ptr;
   logic [CNT_W-1:0]        r_beat_cnt;

   logic [OWN_W-1:0]        w_pick;
   logic [OWN_W-1:0]        w_cur;
   logic [OWN_W-1:0]        w_next_ptr;
   logic                    w_any;
   logic                    w_req_cur;
   logic                    w_last_cur;
   logic                    w_xfer;
   logic                    w_end;
   logic [DATA_WIDTH-1:0]   w_data;

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .OWN_W   (OWN_W)
   ) u_picker (
      .req     (req),
      .rr_ptr  (r_rr_ptr),
      .pick    (w_pick),
      .any_req (w_any)
   );

   assign w_cur = (r_state == OWN) ? r_owner : w_pick;

   always_comb begin
      w_req_cur  = 1'b0;
      w_last_cur = 1'b0;
      w_data     = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_cur == OWN_W'(i)) begin
            w_req_cur  = req[i];
            w_last_cur = req_last[i];
            w_data     = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   // Gating with reset keeps every write-side output quiet while reset is held.
   assign w_xfer     = reset & w_req_cur & ~fifo_wr_full & ((r_state == OWN) | w_any);
   assign w_end      = w_xfer & (w_last_cur |
                                 (({1'b0, r_beat_cnt} + (CNT_W + 1)'(1)) == c_max_burst));
   assign w_next_ptr = OWN_W'(rr_next(int'(w_cur), NUM_REQ));

   always_comb begin
      gnt = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         gnt[i] = w_xfer & (w_cur == OWN_W'(i));
      end
   end

   assign fifo_wr_en   = w_xfer;
   assign fifo_wr_data = w_data;
   assign owner        = reset ? w_cur : '0;
   assign busy         = reset & (r_state == OWN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= IDLE;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_beat_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_xfer) begin
                  if (w_end) begin
                     r_rr_ptr <= w_next_ptr;
                  end else begin
                     r_state    <= OWN;
                     r_owner    <= w_cur;
                     r_beat_cnt <= CNT_W'(1);
                  end
               end
            end
            OWN: begin
               // A withdrawn request releases the port just like a completed burst.
               if (!w_req_cur || w_end) begin
                  r_state    <= IDLE;
                  r_beat_cnt <= '0;
                  r_rr_ptr   <= w_next_ptr;
               end else if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + CNT_W'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fifo_wr_arbiter : directed + randomized bench with burst-level reference model
// Revision           : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_fifo_wr_arbiter;

   localparam int N     = 4;
   localparam int DW    = 16;
   localparam int MB    = 4;
   localparam int OW    = 2;
   localparam int DEPTH = 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic          last;
   } beat_t;

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic [N-1:0]    req = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]    req_last = '0;
   logic [N-1:0]    gnt;
   logic            fifo_wr_full = 1'b0;
   logic            fifo_wr_en;
   logic [DW-1:0]   fifo_wr_data;
   logic [OW-1:0]   owner;
   logic            busy;

   always #5 clk = ~clk;

   fifo_wr_arbiter #(
      .NUM_REQ    (N),
      .DATA_WIDTH (DW),
      .MAX_BURST  (MB)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .req          (req),
      .req_data     (req_data),
      .req_last     (req_last),
      .gnt          (gnt),
      .fifo_wr_full (fifo_wr_full),
      .fifo_wr_en   (fifo_wr_en),
      .fifo_wr_data (fifo_wr_data),
      .owner        (owner),
      .busy         (busy)
   );

   int            checks = 0;
   int            errors = 0;
   beat_t         pq [N][$];
   logic [DW-1:0] fq [$];
   int            gseq [$];
   bit            pop = 1'b0;
   logic [N-1:0]  wd_mask = '0;
   int            m_own = -1;
   int            m_beats = 0;
   int            m_start = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int r, input int n, input logic [DW-1:0] base);
      beat_t b;
      for (int k = 0; k < n; k++) begin
         b.d    = base + DW'(k);
         b.last = (k == n - 1);
         pq[r].push_back(b);
      end
   endtask

   function automatic int pending();
      int s;
      s = 0;
      for (int i = 0; i < N; i++) s += pq[i].size();
      return s;
   endfunction

   task automatic model_reset();
      m_own = -1;
      m_beats = 0;
      m_start = 0;
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (pq[i].size() > 0 && !wd_mask[i]) begin
            req[i]                = 1'b1;
            req_data[i*DW +: DW]  = pq[i][0].d;
            req_last[i]           = pq[i][0].last;
         end else begin
            req[i]      = 1'b0;
            req_last[i] = 1'b0;
         end
      end
      fifo_wr_full = (fq.size() >= DEPTH);
   endtask

   // One clock: drive, check against the burst-level model, then advance everything.
   task automatic tick();
      int           cur;
      bit           x;
      bit           e;
      logic [N-1:0] eg;
      drive();
      #2;
      cur = -1;
      if (m_own >= 0) cur = m_own;
      else
         for (int k = 0; k < N; k++)
            if (cur < 0 && req[(m_start + k) % N]) cur = (m_start + k) % N;
      x  = (cur >= 0) && req[cur] && !fifo_wr_full;
      e  = x && (req_last[cur] || (m_beats + 1 == MB));
      eg = x ? N'(1 << cur) : '0;
      chk("gnt", gnt, eg);
      chk("wr_en", fifo_wr_en, x);
      chk("busy", busy, m_own >= 0);
      chk("onehot", $countones(gnt) <= 1, 1);
      if (cur >= 0) chk("owner", owner, cur);
      if (x) chk("wr_data", fifo_wr_data, pq[cur][0].d);
      if (pop && fq.size() > 0) void'(fq.pop_front());
      if (fifo_wr_en === 1'b1) fq.push_back(fifo_wr_data);
      if (x) begin
         gseq.push_back(cur);
         pq[cur].delete(0);
      end
      if (m_own >= 0) begin
         if (!req[m_own] || e) begin
            m_start = (m_own + 1) % N;
            m_own   = -1;
            m_beats = 0;
         end else if (x) begin
            m_beats++;
         end
      end else if (x) begin
         if (e) m_start = (cur + 1) % N;
         else begin
            m_own   = cur;
            m_beats = 1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input int budget);
      int b;
      b = budget;
      while ((pending() > 0 || (pop && fq.size() > 0)) && b > 0) begin
         tick();
         b--;
      end
      chk("drain_left", pending(), 0);
   endtask

   task automatic full_reset();
      reset = 1'b0;
      #1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int exp_seq [$];
      int mark;

      // Reset state: outputs forced low even with every request raised.
      req = '1;
      req_last = '1;
      #2;
      chk("rst_gnt", gnt, 0);
      chk("rst_wr_en", fifo_wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_owner", owner, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;

      // Single requester, 3-beat burst, then rr_ptr must sit at 2.
      load(1, 3, 16'h00A0);
      tick(); tick(); tick();
      chk("r1_len", gseq.size(), 3);
      for (int k = 0; k < gseq.size(); k++) chk("r1_gnt", gseq[k], 1);
      chk("r1_fifo_n", fq.size(), 3);
      if (fq.size() == 3) begin
         chk("rd0", fq.pop_front(), 16'h00A0);
         chk("rd1", fq.pop_front(), 16'h00A1);
         chk("rd2", fq.pop_front(), 16'h00A2);
      end
      load(0, 1, 16'h0100);
      load(2, 1, 16'h0200);
      tick();
      chk("rr_after_r1", gseq[$], 2);
      tick();

      // Four competing 6-beat bursts from rr_ptr=0.
      full_reset();
      fq.delete();
      gseq.delete();
      pop = 1'b1;
      for (int r = 0; r < N; r++) load(r, 6, DW'(r * 16'h1000));
      drain(60);
      for (int r = 0; r < N; r++) for (int k = 0; k < 4; k++) exp_seq.push_back(r);
      for (int r = 0; r < N; r++) for (int k = 0; k < 2; k++) exp_seq.push_back(r);
      chk("order_len", gseq.size(), 24);
      for (int k = 0; k < 24 && k < gseq.size(); k++) chk("order", gseq[k], exp_seq[k]);
      drain(20);

      // FIFO full: fill to 7, R2 takes the 8th slot and then stalls while owning.
      pop = 1'b0;
      load(0, 7, 16'h0300);
      drain(20);
      chk("fill7", fq.size(), 7);
      load(2, 3, 16'h0400);
      tick(); tick(); tick(); tick();
      chk("full_n", fq.size(), 8);
      chk("full_busy", busy, 1);
      chk("full_owner", owner, 2);
      pop = 1'b1;
      tick();
      pop = 1'b0;
      tick();
      tick();
      chk("one_beat_n", fq.size(), 8);
      chk("one_beat_d", fq[$], 16'h0401);
      chk("kept_busy", busy, 1);
      chk("kept_owner", owner, 2);
      pop = 1'b1;
      drain(30);

      // Withdraw: R3 owns two beats and drops req; R0 follows from rr_ptr=0.
      load(3, 5, 16'h0500);
      load(0, 2, 16'h0600);
      wd_mask = 4'b0001;
      tick(); tick();
      chk("wd_owner", owner, 3);
      wd_mask = 4'b1000;
      tick();
      chk("wd_idle", busy, 0);
      wd_mask = '0;
      tick();
      chk("wd_next", gseq[$], 0);
      drain(30);

      // Reset during R1's second beat.
      load(1, 4, 16'h0700);
      tick();
      drive();
      #1;
      reset = 1'b0;
      #1;
      chk("mid_gnt", gnt, 0);
      chk("mid_wr_en", fifo_wr_en, 0);
      chk("mid_busy", busy, 0);
      model_reset();
      for (int i = 0; i < N; i++) pq[i].delete();
      fq.delete();
      @(posedge clk);
      #1;
      reset = 1'b1;
      load(1, 2, 16'h0800);
      load(3, 1, 16'h0900);
      tick();
      chk("post_rst", gseq[$], 1);
      drain(20);

      // Single-beat bursts from R0 and R2 every cycle alternate with no bubble.
      gseq.delete();
      for (int k = 0; k < 6; k++) begin
         load(0, 1, DW'(16'h0A00 + k));
         load(2, 1, DW'(16'h0B00 + k));
      end
      for (int k = 0; k < 12; k++) tick();
      chk("alt_len", gseq.size(), 12);
      for (int k = 0; k < 12 && k < gseq.size(); k++) chk("alt", gseq[k], (k % 2 == 0) ? 0 : 2);

      // Randomized traffic with stalls and occasional withdrawals.
      for (int c = 0; c < 600; c++) begin
         pop = ($urandom_range(0, 2) != 0);
         for (int i = 0; i < N; i++) begin
            if (pq[i].size() == 0 && $urandom_range(0, 3) == 0)
               load(i, $urandom_range(1, 7), DW'($urandom));
            wd_mask[i] = ($urandom_range(0, 15) == 0);
         end
         tick();
      end
      wd_mask = '0;
      pop = 1'b1;
      drain(200);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
